hex_bridge_rx: RTL
==================

// Module: hex_bridge_rx
// PURPOSE
//  Parametrised ASCII-hex command parser between the UART byte receiver and the core bus.
//  - Decodes read frames "R<addr>\r\n" and write frames "W<addr><data>\r\n" into bus transactions.
//  - Address and data widths are configurable; hex digits are MSB first.
//  - Adds a valid/ready output handshake, an inter-byte timeout and error reporting.
// PARAMETERS
//  ADDR_WIDTH     16    address width in bits; multiple of 4, >=4; frame carries ADDR_WIDTH/4 digits
//  DATA_WIDTH     16    data width in bits; multiple of 4, >=4; write frame carries DATA_WIDTH/4 digits
//  TIMEOUT_CYCLES 0     idle clocks allowed between bytes inside a frame; 0 disables the timeout
//  ALLOW_LOWER    1     1: 'a'-'f' accepted as hex digits; 0: only '0'-'9','A'-'F'
// PORTS
//  clk         in   1           system clock, all logic on rising edge
//  rst         in   1           asynchronous, active-high reset
//  data_i      in   8           received byte
//  valid_i     in   1           data_i valid this cycle (single-cycle strobe, no backpressure)
//  addr_o      out  ADDR_WIDTH  transaction address
//  data_o      out  DATA_WIDTH  write data; 0 for reads
//  rw_o        out  1           1=write, 0=read
//  valid_o     out  1           transaction pending
//  ready_i     in   1           bus accepts transaction when valid_o&&ready_i
//  err_o       out  1           one-cycle pulse: frame error
//  err_code_o  out  2           0=bad char, 1=bad terminator, 2=timeout, 3=overflow; valid with err_o
// BEHAVIOUR
//  Reset: all outputs 0, FSM IDLE, digit counter and accumulators 0, timeout counter 0.
//  FSM: IDLE, ADDR, DATA, CR, LF; only valid_i bytes advance it.
//   IDLE: 'R' -> ADDR (op=read); 'W' -> ADDR (op=write); any other byte ignored, no error.
//   ADDR: hex digit -> shift into addr accumulator (acc<<4|nibble).
//     After ADDR_WIDTH/4 digits: write -> DATA, read -> CR.
//   DATA: hex digit -> shift into data accumulator; after DATA_WIDTH/4 digits -> CR.
//   CR: 0x0D -> LF.  LF: 0x0A -> frame complete, -> IDLE.
//  Hex decode: '0'-'9' -> 0-9; 'A'-'F' -> 10-15; 'a'-'f' -> 10-15 only if ALLOW_LOWER.
//  Errors (err_o pulse next cycle; at most one per cycle):
//   - non-hex byte in ADDR/DATA -> code 0.
//   - wrong byte in CR/LF -> code 1.
//   - In both cases, if the offending byte is 'R'/'W', the FSM restarts a new frame with that op.
//     Otherwise -> IDLE.
//  Timeout: counter clears on each valid_i, counts in non-IDLE states.
//   On reaching TIMEOUT_CYCLES -> IDLE, err code 2. Never fires in IDLE.
//   A valid_i in the same cycle as expiry wins (no timeout).
//  Output register (one entry):
//   - On completed frame: addr_o, data_o (0 for reads), rw_o, valid_o=1, registered.
//   - valid_o rises the cycle after LF is sampled.
//   - Outputs are held stable while valid_o && !ready_i.
//   - valid_o drops the cycle after valid_o&&ready_i unless a new frame loads in the same cycle.
//   - If a frame completes while valid_o && !ready_i: the new frame is dropped, the held
//     transaction is unchanged, err code 3.
//   - If a frame completes in the same cycle the held transaction is accepted: the new frame
//     loads, valid_o stays 1, no error.
//  Parsing continues regardless of output backpressure; valid_i is never stalled.
//  Reset mid-frame or with valid_o pending: the partial frame and pending transaction are discarded.
// TESTING
//  1) Defaults; bytes "R12AF\r\n", ready_i=1.
//     -> one valid_o cycle, addr_o=16'h12AF, rw_o=0, data_o=0, err_o never set.
//  2) "W00ffBEEF\r\n", ALLOW_LOWER=1.
//     -> addr_o=16'h00FF, data_o=16'hBEEF, rw_o=1; with ALLOW_LOWER=0 -> err code 0, no valid_o.
//  3) ready_i=0; "W0001000A\r\n" then "R0002\r\n".
//     -> first held (addr 1, data 0xA); second frame -> err code 3; ready_i=1 -> first accepted.
//  4) "R12W3456ABCD\r\n".
//     -> err code 0 on 'W', then write addr 16'h3456 data 16'hABCD completes.
//  5) TIMEOUT_CYCLES=10; "R12" then 10 idle cycles.
//     -> err code 2, FSM IDLE; subsequent "R0001\r\n" -> addr_o=1.
//  6) ADDR_WIDTH=32, DATA_WIDTH=8; "W89ABCDEF5A\r\n" with rst pulsed after "W89" then frame resent.
//     -> no output from first; second gives addr_o=32'h89ABCDEF, data_o=8'h5A.

Source files
------------

// File: rtl/hex_bridge_rx_if.sv
// hex_bridge_rx_if: byte input, transaction output and error signals of the hex frame parser
interface hex_bridge_rx_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16
);
  logic [7:0]            data_i;
  logic                  valid_i;
  logic [ADDR_WIDTH-1:0] addr_o;
  logic [DATA_WIDTH-1:0] data_o;
  logic                  rw_o;
  logic                  valid_o;
  logic                  ready_i;
  logic                  err_o;
  logic [1:0]            err_code_o;
  modport slave (input data_i, valid_i, ready_i, output addr_o, data_o, rw_o, valid_o, err_o, err_code_o);
  modport master(output data_i, valid_i, ready_i, input addr_o, data_o, rw_o, valid_o, err_o, err_code_o);
endinterface

// File: rtl/hex_bridge_rx.sv
// hex_bridge_rx: parses "R<addr>\r\n" / "W<addr><data>\r\n" byte frames into registered bus transactions
module hex_bridge_rx #(
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 0,
  parameter int ALLOW_LOWER    = 1
) (
  input logic           clk,
  input logic           rst,
  hex_bridge_rx_if.slave bus
);
  localparam int AD = ADDR_WIDTH / 4;
  localparam int DD = DATA_WIDTH / 4;
  localparam int MD = AD > DD ? AD : DD;
  localparam int CW = $clog2(MD + 1);
  localparam int TW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  typedef enum logic [2:0] {IDLE, ADDR, DATA, CR, LF} state_t;
  state_t                state_q, state_d;
  logic                  op_q, op_d;
  logic [ADDR_WIDTH-1:0] acc_a_q, acc_a_d, addr_q, addr_d;
  logic [DATA_WIDTH-1:0] acc_d_q, acc_d_d, data_q, data_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [TW-1:0]         tmo_q, tmo_d;
  logic                  rw_q, rw_d, valid_q, valid_d, err_q, err_d;
  logic [1:0]            code_q, code_d;
  logic [7:0]            b;
  logic [3:0]            nib;
  logic                  is_hex, is_op, last, done, perr, timeout, load;
  always_comb begin
    b       = bus.data_i;
    is_hex  = (b >= "0" && b <= "9") || (b >= "A" && b <= "F") || (ALLOW_LOWER != 0 && b >= "a" && b <= "f");
    nib     = (b <= "9") ? b[3:0] : b[3:0] + 4'd9;
    is_op   = b == "R" || b == "W";
    last    = int'(cnt_q) == ((state_q == DATA ? DD : AD) - 1);
    perr    = bus.valid_i && ((((state_q == ADDR) || (state_q == DATA)) && !is_hex) ||
              (state_q == CR && b != 8'h0D) || (state_q == LF && b != 8'h0A));
    timeout = TIMEOUT_CYCLES != 0 && state_q != IDLE && !bus.valid_i && int'(tmo_q) == TIMEOUT_CYCLES - 1;
    state_d = state_q;
    op_d    = op_q;
    acc_a_d = acc_a_q;
    acc_d_d = acc_d_q;
    cnt_d   = cnt_q;
    done    = 1'b0;
    if (bus.valid_i) begin
      case (state_q)
        ADDR: if (is_hex) begin
          acc_a_d = (acc_a_q << 4) | ADDR_WIDTH'(nib);
          cnt_d   = last ? '0 : cnt_q + CW'(1);
          state_d = !last ? ADDR : op_q ? DATA : CR;
        end
        DATA: if (is_hex) begin
          acc_d_d = (acc_d_q << 4) | DATA_WIDTH'(nib);
          cnt_d   = last ? '0 : cnt_q + CW'(1);
          state_d = last ? CR : DATA;
        end
        CR: if (b == 8'h0D) state_d = LF;
        LF: if (b == 8'h0A) begin
          done    = 1'b1;
          state_d = IDLE;
        end
        default: ;
      endcase
      if (perr) state_d = IDLE;
      // an 'R'/'W' arriving in IDLE or as the offending byte opens a fresh frame
      if ((state_q == IDLE || perr) && is_op) begin
        state_d = ADDR;
        op_d    = b == "W";
        acc_a_d = '0;
        acc_d_d = '0;
        cnt_d   = '0;
      end
    end else if (timeout) state_d = IDLE;
    load    = done && (!valid_q || bus.ready_i);
    valid_d = load || (valid_q && !bus.ready_i);
    addr_d  = load ? acc_a_q : addr_q;
    data_d  = load ? (op_q ? acc_d_q : '0) : data_q;
    rw_d    = load ? op_q : rw_q;
    err_d   = perr || timeout || (done && !load);
    code_d  = (done && !load) ? 2'd3 : timeout ? 2'd2 : (state_q == CR || state_q == LF) ? 2'd1 : 2'd0;
    tmo_d   = (TIMEOUT_CYCLES == 0 || bus.valid_i || state_q == IDLE || timeout) ? '0 : tmo_q + TW'(1);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= 1'b0;
      acc_a_q <= '0;
      acc_d_q <= '0;
      cnt_q   <= '0;
      tmo_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      rw_q    <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      acc_a_q <= acc_a_d;
      acc_d_q <= acc_d_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      rw_q    <= rw_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      code_q  <= code_d;
    end
  end
  assign bus.addr_o     = addr_q;
  assign bus.data_o     = data_q;
  assign bus.rw_o       = rw_q;
  assign bus.valid_o    = valid_q;
  assign bus.err_o      = err_q;
  assign bus.err_code_o = code_q;
endmodule
